// File: rtl/feat_accum_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : feat_accum_ctrl
// Purpose  : Feature-SRAM initiator for the conv/FC accumulation path.
//            Accumulate pass: pipelined read-modify-write of partial products
//            (read via port 2, saturated sum written back via port 1).
//            Readout pass: streams stored words out of port 1 with a
//            valid/ready handshake.
// Ports    : clk, rst                    clock / async active-high reset
//            start, mode, clear, size    pass command (sampled in IDLE)
//            in_valid, in_data, in_ready partial-product input stream
//            out_valid, out_data, out_ready  readout stream
//            mem_we1, mem_addr1, write_data1, read_data1   SRAM port 1
//            mem_addr2, read_data2       SRAM port 2 (read only)
//            busy, done                  status
// Revision : 1.0 - initial release
// ============================================================================
module feat_accum_ctrl #(
   parameter int DWIDTH = 16,
   parameter int FACCUM = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              mode,
   input  logic              clear,
   input  logic [FACCUM:0]   size,
   input  logic              in_valid,
   input  logic [DWIDTH-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DWIDTH-1:0] out_data,
   input  logic              out_ready,
   output logic              mem_we1,
   output logic [FACCUM-1:0] mem_addr1,
   output logic [DWIDTH-1:0] write_data1,
   output logic [FACCUM-1:0] mem_addr2,
   input  logic [DWIDTH-1:0] read_data1,
   input  logic [DWIDTH-1:0] read_data2,
   output logic              busy,
   output logic              done
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ACC    = 3'd1;
   localparam logic [2:0] S_FLUSH  = 3'd2;
   localparam logic [2:0] S_RD_REQ = 3'd3;
   localparam logic [2:0] S_RD_OUT = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;

   localparam logic [FACCUM:0]   c_one     = {{FACCUM{1'b0}}, 1'b1};
   localparam logic [DWIDTH-1:0] c_sat_max = {1'b0, {(DWIDTH-1){1'b1}}};
   localparam logic [DWIDTH-1:0] c_sat_min = {1'b1, {(DWIDTH-1){1'b0}}};

   logic [2:0]        r_state;
   logic [FACCUM:0]   r_cnt;
   logic [FACCUM:0]   r_size;
   logic              r_clear;
   logic [DWIDTH-1:0] r_data_d1;
   logic [FACCUM-1:0] r_addr_d1;
   logic              r_v_d1;

   logic [FACCUM:0]   w_cnt_inc;
   logic              w_last;
   logic [DWIDTH:0]   w_sum;
   logic [DWIDTH-1:0] w_sat;

   // cnt is one bit wider than the address so a full-depth pass
   // (size = 2**FACCUM) terminates without wrapping.
   assign w_cnt_inc = r_cnt + c_one;
   assign w_last    = (w_cnt_inc == r_size);

   // Sign-extended add: the extra bit lets overflow be detected as a
   // disagreement between the two top bits.
   assign w_sum = {read_data2[DWIDTH-1], read_data2} + {r_data_d1[DWIDTH-1], r_data_d1};

   always_comb begin
      w_sat = w_sum[DWIDTH-1:0];
      if (w_sum[DWIDTH] != w_sum[DWIDTH-1]) begin
         w_sat = w_sum[DWIDTH] ? c_sat_min : c_sat_max;
      end
   end

   // ------------------------------------------------------------------------
   // Control state and pipeline registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_size    <= '0;
         r_clear   <= 1'b0;
         r_data_d1 <= '0;
         r_addr_d1 <= '0;
         r_v_d1    <= 1'b0;
      end else begin
         // The write stage is live only in the cycle after an accepted beat.
         r_v_d1 <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_size  <= size;
                  r_clear <= clear;
                  r_cnt   <= '0;
                  if (size == '0) begin
                     r_state <= S_DONE;
                  end else if (mode) begin
                     r_state <= S_RD_REQ;
                  end else begin
                     r_state <= S_ACC;
                  end
               end
            end
            S_ACC: begin
               if (in_valid) begin
                  r_data_d1 <= in_data;
                  r_addr_d1 <= r_cnt[FACCUM-1:0];
                  r_v_d1    <= 1'b1;
                  r_cnt     <= w_cnt_inc;
                  if (w_last) begin
                     r_state <= S_FLUSH;
                  end
               end
            end
            S_FLUSH: begin
               // Final beat's write happens in this cycle.
               r_state <= S_DONE;
            end
            S_RD_REQ: begin
               r_state <= S_RD_OUT;
            end
            S_RD_OUT: begin
               if (out_ready) begin
                  r_cnt   <= w_cnt_inc;
                  r_state <= w_last ? S_DONE : S_RD_REQ;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Outputs (all zero in IDLE, hence zero immediately on reset)
   // ------------------------------------------------------------------------
   always_comb begin
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      out_data    = '0;
      mem_we1     = r_v_d1;
      mem_addr1   = '0;
      write_data1 = '0;
      mem_addr2   = '0;
      busy        = (r_state != S_IDLE);
      done        = (r_state == S_DONE);

      if (r_state == S_ACC) begin
         in_ready  = 1'b1;
         mem_addr2 = r_cnt[FACCUM-1:0];
      end

      // Port 1 is shared: the write stage (ACC/FLUSH) and the readout
      // states are never active at the same time.
      if (r_v_d1) begin
         mem_addr1   = r_addr_d1;
         write_data1 = r_clear ? r_data_d1 : w_sat;
      end else if ((r_state == S_RD_REQ) || (r_state == S_RD_OUT)) begin
         mem_addr1 = r_cnt[FACCUM-1:0];
      end

      if (r_state == S_RD_OUT) begin
         out_valid = 1'b1;
         out_data  = read_data1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_feat_accum_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_feat_accum_ctrl
// Purpose  : Directed self-checking bench for feat_accum_ctrl with a
//            behavioural dual-port SRAM (registered read addresses).
// Revision : 1.0 - initial release
// ============================================================================
module tb_feat_accum_ctrl;

   localparam int DW    = 16;
   localparam int FA    = 10;
   localparam int DEPTH = 1 << FA;

   logic          clk;
   logic          rst;
   logic          start;
   logic          mode;
   logic          clear;
   logic [FA:0]   size;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_ready;
   logic          mem_we1;
   logic [FA-1:0] mem_addr1;
   logic [DW-1:0] write_data1;
   logic [FA-1:0] mem_addr2;
   logic [DW-1:0] read_data1;
   logic [DW-1:0] read_data2;
   logic          busy;
   logic          done;

   feat_accum_ctrl #(.DWIDTH(DW), .FACCUM(FA)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .mode        (mode),
      .clear       (clear),
      .size        (size),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_ready   (out_ready),
      .mem_we1     (mem_we1),
      .mem_addr1   (mem_addr1),
      .write_data1 (write_data1),
      .mem_addr2   (mem_addr2),
      .read_data1  (read_data1),
      .read_data2  (read_data2),
      .busy        (busy),
      .done        (done)
   );

   // Behavioural SRAM: write on port 1, registered read addresses on both ports.
   logic [DW-1:0] mem [DEPTH];
   logic [FA-1:0] ra1;
   logic [FA-1:0] ra2;

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      ra1 = '0;
      ra2 = '0;
   end

   always @(posedge clk) begin
      if (mem_we1) mem[mem_addr1] <= write_data1;
      ra1 <= mem_addr1;
      ra2 <= mem_addr2;
   end

   assign read_data1 = mem[ra1];
   assign read_data2 = mem[ra2];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int we_cnt   = 0;
   int done_cnt = 0;
   always @(negedge clk) begin
      if (mem_we1) we_cnt++;
      if (done)    done_cnt++;
   end

   int checks   = 0;
   int failures = 0;

   logic [DW-1:0] vec  [DEPTH];
   logic [DW-1:0] expv [DEPTH];

   task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%h) want %0d (0x%h)", tag, act, act, exp, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_vec(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [15:0] d);
      vec[0] = a; vec[1] = b; vec[2] = c; vec[3] = d;
   endtask

   task automatic set_exp(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [15:0] d);
      expv[0] = a; expv[1] = b; expv[2] = c; expv[3] = d;
   endtask

   task automatic start_pass(input logic m, input logic c, input logic [FA:0] n);
      start = 1'b1; mode = m; clear = c; size = n;
      step();
      start = 1'b0; mode = 1'b0; clear = 1'b0; size = '0;
   endtask

   // Returns in the IDLE cycle following the DONE pulse.
   task automatic wait_done(input string tag);
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         step();
      end
      chk(tag, {15'd0, seen}, 16'd1);
      step();
   endtask

   task automatic feed(input int n, input bit gap);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_data  = vec[i];
         chk("in_ready", {15'd0, in_ready}, 16'd1);
         step();
         in_valid = 1'b0;
         in_data  = '0;
         chk("we_after_beat", {15'd0, mem_we1}, 16'd1);
         if (gap && i != n - 1) begin
            step();
            chk("we_in_gap", {15'd0, mem_we1}, 16'd0);
         end
      end
      chk("flush_in_ready", {15'd0, in_ready}, 16'd0);
   endtask

   task automatic acc_pass(input logic c, input int n, input bit gap);
      int we0, d0;
      we0 = we_cnt;
      d0  = done_cnt;
      start_pass(1'b0, c, n[FA:0]);
      feed(n, gap);
      wait_done("acc_done");
      chk("acc_we_count", 16'(we_cnt - we0), 16'(n));
      chk("acc_done_count", 16'(done_cnt - d0), 16'd1);
   endtask

   task automatic read_pass(input int n, input bit stall, input bit inject);
      int we0, d0;
      logic ok;
      we0 = we_cnt;
      d0  = done_cnt;
      start_pass(1'b1, 1'b0, n[FA:0]);
      for (int i = 0; i < n; i++) begin
         ok = 1'b0;
         for (int k = 0; k < 4; k++) begin
            if (out_valid) begin
               ok = 1'b1;
               break;
            end
            step();
         end
         chk("out_valid", {15'd0, ok}, 16'd1);
         chk("out_data", out_data, expv[i]);
         if (stall) begin
            for (int j = 0; j < 3; j++) begin
               if (inject && i == 1 && j == 0) begin
                  start = 1'b1; mode = 1'b0; clear = 1'b1; size = 11'd1;
               end
               step();
               start = 1'b0; clear = 1'b0; size = '0;
               chk("stall_valid", {15'd0, out_valid}, 16'd1);
               chk("stall_hold", out_data, expv[i]);
            end
         end
         out_ready = 1'b1;
         step();
         out_ready = 1'b0;
      end
      wait_done("rd_done");
      chk("rd_we_count", 16'(we_cnt - we0), 16'd0);
      chk("rd_done_count", 16'(done_cnt - d0), 16'd1);
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_busy"},      {15'd0, busy},      16'd0);
      chk({tag, "_done"},      {15'd0, done},      16'd0);
      chk({tag, "_in_ready"},  {15'd0, in_ready},  16'd0);
      chk({tag, "_out_valid"}, {15'd0, out_valid}, 16'd0);
      chk({tag, "_out_data"},  out_data,           16'd0);
      chk({tag, "_we1"},       {15'd0, mem_we1},   16'd0);
      chk({tag, "_addr1"},     {6'd0, mem_addr1},  16'd0);
      chk({tag, "_wdata1"},    write_data1,        16'd0);
      chk({tag, "_addr2"},     {6'd0, mem_addr2},  16'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; mode = 1'b0; clear = 1'b0; size = '0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      step();
      step();
      chk_outputs_zero("reset");
      rst = 1'b0;
      step();

      // Clear pass 1..4, then readout
      set_vec(16'd1, 16'd2, 16'd3, 16'd4);
      acc_pass(1'b1, 4, 1'b0);
      set_exp(16'd1, 16'd2, 16'd3, 16'd4);
      read_pass(4, 1'b0, 1'b0);

      // Accumulate 10,-20,30,-40
      set_vec(16'd10, -16'sd20, 16'd30, -16'sd40);
      acc_pass(1'b0, 4, 1'b0);
      set_exp(16'd11, -16'sd18, 16'd33, -16'sd36);
      read_pass(4, 1'b0, 1'b0);

      // Saturation at both rails
      set_vec(16'd32000, -16'sd32000, 16'd0, 16'd0);
      acc_pass(1'b1, 2, 1'b0);
      set_vec(16'd1000, -16'sd1000, 16'd0, 16'd0);
      acc_pass(1'b0, 2, 1'b0);
      set_exp(16'h7FFF, 16'h8000, 16'd0, 16'd0);
      read_pass(2, 1'b0, 1'b0);

      // Same data as the no-stall run, with input gaps and output backpressure
      set_vec(16'd1, 16'd2, 16'd3, 16'd4);
      acc_pass(1'b1, 4, 1'b1);
      set_vec(16'd10, -16'sd20, 16'd30, -16'sd40);
      acc_pass(1'b0, 4, 1'b1);
      set_exp(16'd11, -16'sd18, 16'd33, -16'sd36);
      read_pass(4, 1'b1, 1'b0);

      // size == 0: straight to DONE, no writes
      begin
         int we0;
         we0 = we_cnt;
         start_pass(1'b0, 1'b0, '0);
         chk("size0_busy", {15'd0, busy}, 16'd1);
         chk("size0_done", {15'd0, done}, 16'd1);
         chk("size0_we1", {15'd0, mem_we1}, 16'd0);
         step();
         chk("size0_busy_after", {15'd0, busy}, 16'd0);
         chk("size0_done_after", {15'd0, done}, 16'd0);
         chk("size0_we_count", 16'(we_cnt - we0), 16'd0);
      end

      // start while busy (readout in progress) must be ignored
      read_pass(4, 1'b1, 1'b1);

      // Reset after 2 of 4 accumulate beats (beat 1's write already committed)
      start_pass(1'b0, 1'b0, 11'd4);
      in_valid = 1'b1; in_data = 16'd1;
      step();
      step();
      in_valid = 1'b0; in_data = '0;
      step();
      chk("pre_rst_busy", {15'd0, busy}, 16'd1);
      chk("pre_rst_addr2", {6'd0, mem_addr2}, 16'd2);
      rst = 1'b1;
      #1;
      chk_outputs_zero("midrst");
      step();
      rst = 1'b0;
      chk("rst_mem0", mem[0], 16'd12);
      chk("rst_mem1", mem[1], -16'sd17);
      chk("rst_mem2", mem[2], 16'd33);
      chk("rst_mem3", mem[3], -16'sd36);
      step();
      set_exp(16'd12, -16'sd17, 16'd33, -16'sd36);
      read_pass(4, 1'b0, 1'b0);

      // size == 1 passes back to back: last write visible to the next pass
      set_vec(16'd5, 16'd0, 16'd0, 16'd0);
      acc_pass(1'b1, 1, 1'b0);
      set_vec(16'd7, 16'd0, 16'd0, 16'd0);
      acc_pass(1'b0, 1, 1'b0);
      set_exp(16'd12, 16'd0, 16'd0, 16'd0);
      read_pass(1, 1'b0, 1'b0);

      // Full-depth pass: addresses 0..DEPTH-1, no wrap
      for (int i = 0; i < DEPTH; i++) begin
         vec[i]  = 16'(i * 3 + 1);
         expv[i] = 16'(i * 3 + 1);
      end
      acc_pass(1'b1, DEPTH, 1'b0);
      read_pass(DEPTH, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
